// File: rtl/axi_lite_imem_arbiter_if.sv
// Shared AXI-Lite widths/response codes and the AXI-Lite channel bundle used by the
// instruction-memory arbiter.
package axi_lite_pkg;
  parameter int unsigned ADDR_WIDTH = 32;
  parameter int unsigned DATA_WIDTH = 32;
  parameter logic [1:0]  RESP_OKAY   = 2'b00;
  parameter logic [1:0]  RESP_SLVERR = 2'b10;
endpackage

interface axi_lite_if;
  logic [axi_lite_pkg::ADDR_WIDTH-1:0]   awaddr;
  logic                                  awvalid;
  logic                                  awready;
  logic [axi_lite_pkg::DATA_WIDTH-1:0]   wdata;
  logic [axi_lite_pkg::DATA_WIDTH/8-1:0] wstrb;
  logic                                  wvalid;
  logic                                  wready;
  logic [1:0]                            bresp;
  logic                                  bvalid;
  logic                                  bready;
  logic [axi_lite_pkg::ADDR_WIDTH-1:0]   araddr;
  logic                                  arvalid;
  logic                                  arready;
  logic [axi_lite_pkg::DATA_WIDTH-1:0]   rdata;
  logic [1:0]                            rresp;
  logic                                  rvalid;
  logic                                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_imem_arbiter.sv
// Two-master AXI-Lite arbiter in front of one memory slave: one transaction in flight,
// round-robin grant, response timeout with local SLVERR completion and late-response drain.
module axi_lite_imem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES   = 256,
  parameter logic        RESET_LAST_GRANT = 1'b1
) (
  input  logic      aclk,
  input  logic      areset,
  axi_lite_if.slave  s0_axi_lite,
  axi_lite_if.slave  s1_axi_lite,
  axi_lite_if.master m_axi_lite,
  output logic      grant_idx,
  output logic      busy,
  output logic      timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StArFwd, StRFwd, StAwFwd, StWFwd, StBFwd, StErrR, StErrB
  } state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            drain_r_q, drain_r_d;
  logic            drain_b_q, drain_b_d;
  logic            terr_q, terr_d;

  logic req0, req1, arb_sel;
  logic g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;
  logic idle, fwd_ar, fwd_r, fwd_aw, fwd_w, fwd_b, err_r, err_b, sel0, sel1;

  assign req0    = s0_axi_lite.arvalid | s0_axi_lite.awvalid;
  assign req1    = s1_axi_lite.arvalid | s1_axi_lite.awvalid;
  assign arb_sel = (req0 && req1) ? ~last_q : req1;

  assign g_arvalid = grant_q ? s1_axi_lite.arvalid : s0_axi_lite.arvalid;
  assign g_awvalid = grant_q ? s1_axi_lite.awvalid : s0_axi_lite.awvalid;
  assign g_wvalid  = grant_q ? s1_axi_lite.wvalid  : s0_axi_lite.wvalid;
  assign g_rready  = grant_q ? s1_axi_lite.rready  : s0_axi_lite.rready;
  assign g_bready  = grant_q ? s1_axi_lite.bready  : s0_axi_lite.bready;

  assign idle   = (state_q == StIdle);
  assign fwd_ar = (state_q == StArFwd);
  assign fwd_r  = (state_q == StRFwd);
  assign fwd_aw = (state_q == StAwFwd);
  assign fwd_w  = (state_q == StWFwd);
  assign fwd_b  = (state_q == StBFwd);
  assign err_r  = (state_q == StErrR);
  assign err_b  = (state_q == StErrB);
  assign sel0   = ~grant_q;
  assign sel1   = grant_q;

  // Downstream request channels: only the channel owned by the current state is live.
  assign m_axi_lite.arvalid = fwd_ar & g_arvalid;
  assign m_axi_lite.araddr  = fwd_ar ? (grant_q ? s1_axi_lite.araddr : s0_axi_lite.araddr) : '0;
  assign m_axi_lite.awvalid = fwd_aw & g_awvalid;
  assign m_axi_lite.awaddr  = fwd_aw ? (grant_q ? s1_axi_lite.awaddr : s0_axi_lite.awaddr) : '0;
  assign m_axi_lite.wvalid  = fwd_w & g_wvalid;
  assign m_axi_lite.wdata   = fwd_w ? (grant_q ? s1_axi_lite.wdata : s0_axi_lite.wdata) : '0;
  assign m_axi_lite.wstrb   = fwd_w ? (grant_q ? s1_axi_lite.wstrb : s0_axi_lite.wstrb) : '0;
  // While draining after a timeout, the stale response is accepted and thrown away.
  assign m_axi_lite.rready  = (fwd_r & g_rready) | (idle & drain_r_q);
  assign m_axi_lite.bready  = (fwd_b & g_bready) | (idle & drain_b_q);

  assign s0_axi_lite.arready = sel0 & fwd_ar & m_axi_lite.arready;
  assign s0_axi_lite.awready = sel0 & fwd_aw & m_axi_lite.awready;
  assign s0_axi_lite.wready  = sel0 & fwd_w & m_axi_lite.wready;
  assign s0_axi_lite.rvalid  = sel0 & ((fwd_r & m_axi_lite.rvalid) | err_r);
  assign s0_axi_lite.rdata   = (sel0 & fwd_r) ? m_axi_lite.rdata : '0;
  assign s0_axi_lite.rresp   = (sel0 & fwd_r) ? m_axi_lite.rresp : (sel0 & err_r) ? RespSlverr
                                                                                   : RespOkay;
  assign s0_axi_lite.bvalid  = sel0 & ((fwd_b & m_axi_lite.bvalid) | err_b);
  assign s0_axi_lite.bresp   = (sel0 & fwd_b) ? m_axi_lite.bresp : (sel0 & err_b) ? RespSlverr
                                                                                   : RespOkay;

  assign s1_axi_lite.arready = sel1 & fwd_ar & m_axi_lite.arready;
  assign s1_axi_lite.awready = sel1 & fwd_aw & m_axi_lite.awready;
  assign s1_axi_lite.wready  = sel1 & fwd_w & m_axi_lite.wready;
  assign s1_axi_lite.rvalid  = sel1 & ((fwd_r & m_axi_lite.rvalid) | err_r);
  assign s1_axi_lite.rdata   = (sel1 & fwd_r) ? m_axi_lite.rdata : '0;
  assign s1_axi_lite.rresp   = (sel1 & fwd_r) ? m_axi_lite.rresp : (sel1 & err_r) ? RespSlverr
                                                                                   : RespOkay;
  assign s1_axi_lite.bvalid  = sel1 & ((fwd_b & m_axi_lite.bvalid) | err_b);
  assign s1_axi_lite.bresp   = (sel1 & fwd_b) ? m_axi_lite.bresp : (sel1 & err_b) ? RespSlverr
                                                                                   : RespOkay;

  assign grant_idx   = grant_q;
  assign busy        = ~idle;
  assign timeout_err = terr_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    drain_r_d = drain_r_q;
    drain_b_d = drain_b_q;
    terr_d    = terr_q;
    unique case (state_q)
      StIdle: begin
        if (drain_r_q && m_axi_lite.rvalid) drain_r_d = 1'b0;
        if (drain_b_q && m_axi_lite.bvalid) drain_b_d = 1'b0;
        if (!drain_r_q && !drain_b_q && (req0 || req1)) begin
          grant_d = arb_sel;
          last_d  = arb_sel;
          state_d = (arb_sel ? s1_axi_lite.arvalid : s0_axi_lite.arvalid) ? StArFwd : StAwFwd;
        end
      end
      StArFwd: begin
        if (g_arvalid && m_axi_lite.arready) begin
          state_d = StRFwd;
          cnt_d   = '0;
        end
      end
      StRFwd: begin
        // A response landing on the timeout cycle still completes normally.
        if (m_axi_lite.rvalid && g_rready) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d   = StErrR;
          drain_r_d = 1'b1;
          terr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAwFwd: if (g_awvalid && m_axi_lite.awready) state_d = StWFwd;
      StWFwd: begin
        if (g_wvalid && m_axi_lite.wready) begin
          state_d = StBFwd;
          cnt_d   = '0;
        end
      end
      StBFwd: begin
        if (m_axi_lite.bvalid && g_bready) begin
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          state_d   = StErrB;
          drain_b_d = 1'b1;
          terr_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StErrR: if (g_rready) state_d = StIdle;
      StErrB: if (g_bready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      last_q    <= RESET_LAST_GRANT;
      cnt_q     <= '0;
      drain_r_q <= 1'b0;
      drain_b_q <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      drain_r_q <= drain_r_d;
      drain_b_q <= drain_b_d;
      terr_q    <= terr_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_imem_arbiter.sv
// Directed bench for the AXI-Lite instruction-memory arbiter (TIMEOUT_CYCLES=4).
module tb_axi_lite_imem_arbiter;
  import axi_lite_pkg::*;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic grant_idx, busy, timeout_err;
  int   errors = 0;
  int   checks = 0;

  axi_lite_if s0_if ();
  axi_lite_if s1_if ();
  axi_lite_if m_if ();

  axi_lite_imem_arbiter #(
    .TIMEOUT_CYCLES  (4),
    .RESET_LAST_GRANT(1'b1)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .s0_axi_lite(s0_if),
    .s1_axi_lite(s1_if),
    .m_axi_lite (m_if),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_all();
    s0_if.arvalid = 0; s0_if.araddr = '0; s0_if.awvalid = 0; s0_if.awaddr = '0;
    s0_if.wvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.rready = 0; s0_if.bready = 0;
    s1_if.arvalid = 0; s1_if.araddr = '0; s1_if.awvalid = 0; s1_if.awaddr = '0;
    s1_if.wvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.rready = 0; s1_if.bready = 0;
    m_if.arready = 0; m_if.awready = 0; m_if.wready = 0; m_if.rvalid = 0; m_if.rdata = '0;
    m_if.rresp = '0; m_if.bvalid = 0; m_if.bresp = '0;
  endtask

  task automatic set_wr(input bit who, input logic [31:0] a, input logic [31:0] d);
    if (who) begin
      s1_if.awvalid = 1; s1_if.awaddr = a; s1_if.wvalid = 1; s1_if.wdata = d; s1_if.wstrb = 4'hf;
    end else begin
      s0_if.awvalid = 1; s0_if.awaddr = a; s0_if.wvalid = 1; s0_if.wdata = d; s0_if.wstrb = 4'hf;
    end
  endtask

  // Entered with the DUT just moved into AW_FWD for master 'who'.
  task automatic do_write(input bit who, input logic [31:0] a, input logic [31:0] d);
    settle();
    chk("wr_grant", grant_idx, who);
    chk("wr_busy", busy, 1);
    chk("wr_m_awvalid", m_if.awvalid, 1);
    chk("wr_m_awaddr", m_if.awaddr, a);
    chk("wr_m_wvalid_gated", m_if.wvalid, 0);
    m_if.awready = 1;
    settle();
    chk("wr_awready", who ? s1_if.awready : s0_if.awready, 1);
    chk("wr_other_awready", who ? s0_if.awready : s1_if.awready, 0);
    tick();
    m_if.awready = 0;
    if (who) s1_if.awvalid = 0; else s0_if.awvalid = 0;
    m_if.wready = 1;
    settle();
    chk("wr_m_wdata", m_if.wdata, d);
    chk("wr_m_awvalid_gated", m_if.awvalid, 0);
    chk("wr_wready", who ? s1_if.wready : s0_if.wready, 1);
    tick();
    m_if.wready = 0;
    if (who) s1_if.wvalid = 0; else s0_if.wvalid = 0;
    m_if.bvalid = 1; m_if.bresp = RESP_OKAY;
    if (who) s1_if.bready = 1; else s0_if.bready = 1;
    settle();
    chk("wr_bvalid", who ? s1_if.bvalid : s0_if.bvalid, 1);
    chk("wr_bresp", who ? s1_if.bresp : s0_if.bresp, RESP_OKAY);
    chk("wr_other_bvalid", who ? s0_if.bvalid : s1_if.bvalid, 0);
    chk("wr_m_bready", m_if.bready, 1);
    tick();
    m_if.bvalid = 0;
    if (who) s1_if.bready = 0; else s0_if.bready = 0;
    settle();
    chk("wr_done_idle", busy, 0);
  endtask

  // Entered with the DUT just moved into AR_FWD for master 'who'.
  task automatic do_read(input bit who, input logic [31:0] a, input logic [31:0] d);
    settle();
    chk("rd_grant", grant_idx, who);
    chk("rd_busy", busy, 1);
    chk("rd_m_arvalid", m_if.arvalid, 1);
    chk("rd_m_araddr", m_if.araddr, a);
    chk("rd_m_awvalid_gated", m_if.awvalid, 0);
    m_if.arready = 1;
    settle();
    chk("rd_arready", who ? s1_if.arready : s0_if.arready, 1);
    chk("rd_other_arready", who ? s0_if.arready : s1_if.arready, 0);
    tick();
    m_if.arready = 0;
    if (who) s1_if.arvalid = 0; else s0_if.arvalid = 0;
    m_if.rvalid = 1; m_if.rdata = d; m_if.rresp = RESP_OKAY;
    if (who) s1_if.rready = 1; else s0_if.rready = 1;
    settle();
    chk("rd_rvalid", who ? s1_if.rvalid : s0_if.rvalid, 1);
    chk("rd_rdata", who ? s1_if.rdata : s0_if.rdata, d);
    chk("rd_rresp", who ? s1_if.rresp : s0_if.rresp, RESP_OKAY);
    chk("rd_other_rvalid", who ? s0_if.rvalid : s1_if.rvalid, 0);
    chk("rd_m_rready", m_if.rready, 1);
    tick();
    m_if.rvalid = 0; m_if.rdata = '0;
    if (who) s1_if.rready = 0; else s0_if.rready = 0;
    settle();
    chk("rd_done_idle", busy, 0);
  endtask

  initial begin
    clear_all();
    areset = 1;
    tick();
    tick();
    areset = 0;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_s0_arready", s0_if.arready, 0);
    chk("rst_s1_wready", s1_if.wready, 0);
    chk("rst_m_arvalid", m_if.arvalid, 0);
    chk("rst_m_rready", m_if.rready, 0);

    // Lone s0 read: one arbitration cycle, then pass-through.
    s0_if.arvalid = 1; s0_if.araddr = 32'h10;
    settle();
    chk("arb_cycle_m_arvalid", m_if.arvalid, 0);
    chk("arb_cycle_busy", busy, 0);
    tick();
    do_read(0, 32'h10, 32'hDEAD_BEEF);

    // Simultaneous writes after reset: s0, s1, then s0 again.
    areset = 1;
    tick();
    areset = 0;
    set_wr(0, 32'h100, 32'h1111_1111);
    set_wr(1, 32'h200, 32'h2222_2222);
    tick();
    do_write(0, 32'h100, 32'h1111_1111);
    tick();
    do_write(1, 32'h200, 32'h2222_2222);
    set_wr(0, 32'h104, 32'h4444_4444);
    set_wr(1, 32'h204, 32'h5555_5555);
    tick();
    do_write(0, 32'h104, 32'h4444_4444);
    tick();
    do_write(1, 32'h204, 32'h5555_5555);

    // s1 read and write together: read first.
    s1_if.arvalid = 1; s1_if.araddr = 32'h300;
    set_wr(1, 32'h304, 32'h3333_3333);
    tick();
    do_read(1, 32'h300, 32'hCAFE_F00D);
    tick();
    do_write(1, 32'h304, 32'h3333_3333);

    // Response on the timeout cycle completes normally.
    s0_if.arvalid = 1; s0_if.araddr = 32'h40;
    tick();
    m_if.arready = 1;
    tick();
    m_if.arready = 0; s0_if.arvalid = 0; s0_if.rready = 1;
    tick();
    tick();
    tick();
    m_if.rvalid = 1; m_if.rdata = 32'h1234_5678; m_if.rresp = RESP_OKAY;
    settle();
    chk("edge_rvalid", s0_if.rvalid, 1);
    chk("edge_rdata", s0_if.rdata, 32'h1234_5678);
    chk("edge_rresp", s0_if.rresp, RESP_OKAY);
    tick();
    m_if.rvalid = 0; m_if.rdata = '0; s0_if.rready = 0;
    settle();
    chk("edge_terr", timeout_err, 0);
    chk("edge_idle", busy, 0);
    chk("edge_no_drain", m_if.rready, 0);

    // Read timeout: SLVERR after 4 R_FWD cycles, then drain of late data.
    s0_if.arvalid = 1; s0_if.araddr = 32'h50;
    tick();
    m_if.arready = 1;
    tick();
    m_if.arready = 0; s0_if.arvalid = 0;
    settle();
    chk("to_wait_rvalid", s0_if.rvalid, 0);
    tick();
    tick();
    tick();
    settle();
    chk("to_last_busy", busy, 1);
    chk("to_last_terr", timeout_err, 0);
    chk("to_last_rvalid", s0_if.rvalid, 0);
    tick();
    m_if.rvalid = 1; m_if.rdata = 32'h55;
    settle();
    chk("to_err_rvalid", s0_if.rvalid, 1);
    chk("to_err_rresp", s0_if.rresp, RESP_SLVERR);
    chk("to_err_rdata", s0_if.rdata, 0);
    chk("to_err_terr", timeout_err, 1);
    chk("to_err_m_rready", m_if.rready, 0);
    s0_if.rready = 1;
    s1_if.arvalid = 1; s1_if.araddr = 32'h60;
    tick();
    s0_if.rready = 0;
    settle();
    chk("drain_busy", busy, 0);
    chk("drain_m_rready", m_if.rready, 1);
    chk("drain_s0_rvalid", s0_if.rvalid, 0);
    chk("drain_s1_rvalid", s1_if.rvalid, 0);
    chk("drain_s1_arready", s1_if.arready, 0);
    tick();
    m_if.rvalid = 0; m_if.rdata = '0;
    settle();
    chk("drain_blocked_busy", busy, 0);
    chk("drain_cleared_rready", m_if.rready, 0);
    tick();
    do_read(1, 32'h60, 32'hA5A5_A5A5);
    chk("terr_sticky", timeout_err, 1);

    // Reset in W_FWD abandons the write; next tie goes to master 0.
    set_wr(0, 32'h700, 32'h7777_7777);
    tick();
    m_if.awready = 1;
    tick();
    m_if.awready = 0; s0_if.awvalid = 0;
    settle();
    chk("wfwd_m_wvalid", m_if.wvalid, 1);
    areset = 1;
    tick();
    settle();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wready", s0_if.wready, 0);
    chk("mid_rst_awready", s0_if.awready, 0);
    chk("mid_rst_m_wvalid", m_if.wvalid, 0);
    chk("mid_rst_terr", timeout_err, 0);
    chk("mid_rst_grant", grant_idx, 0);
    areset = 0;
    s0_if.awvalid = 1;
    s1_if.arvalid = 1; s1_if.araddr = 32'h80;
    tick();
    do_write(0, 32'h700, 32'h7777_7777);
    tick();
    do_read(1, 32'h80, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
